friscv_mem_arbiter: RTL and testbench

Shares one single-port memory interface between the instruction fetch port and the load/store data port of the rv32i core. It grants one requester at a time and uses round-robin when both request together. Address, write data and strobes are registered onto the memory port, and the completion handshake is routed back to the granted requester. A watchdog releases the bus if memory never answers.

---
 rtl/friscv_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_friscv_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_mem_arbiter.sv
// friscv_mem_arbiter: shares one single-port memory between the instruction
// fetch port and the load/store port. One requester is served at a time,
// ties are broken round-robin, and a watchdog frees the bus when the memory
// never answers.
//
// Handshake: a requester raises en with its address/data/strobes and keeps
// them stable until its ready is seen high; the access completes in that
// ready cycle. On the memory side ram_en and ram_* stay stable until the
// cycle where ram_ready=1, which is the completion cycle.
module friscv_mem_arbiter #(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              aclk,
  input  logic              srstn,
  // instruction fetch port
  input  logic              inst_en,
  input  logic [ADDRW-1:0]  inst_addr,
  output logic [XLEN-1:0]   inst_rdata,
  output logic              inst_ready,
  // load/store port
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [ADDRW-1:0]  mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN/8-1:0] mem_strb,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_ready,
  // shared memory port
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDRW-1:0]  ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic [XLEN/8-1:0] ram_strb,
  input  logic [XLEN-1:0]   ram_rdata,
  input  logic              ram_ready,
  // status
  output logic              bus_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INST = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  // Counter wide enough to hold TIMEOUT itself; a zero TIMEOUT keeps one bit.
  localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   WD_LIMIT = CW'(TIMEOUT);
  localparam bit              WD_ON    = (TIMEOUT != 0);

  logic [1:0]    state;
  logic          last_data;   // 1: data port was served last, so inst wins a tie
  logic [CW-1:0] wd_cnt;
  logic          expired;
  logic          done;
  logic          grant_inst;
  logic          grant_data;

  // Arbitration, completion and watchdog expiry decode.
  always_comb begin
    expired    = 1'b0;
    if (WD_ON) begin
      expired = (state != IDLE) && !ram_ready && (wd_cnt == WD_LIMIT);
    end
    done       = (state != IDLE) && (ram_ready || expired);
    grant_inst = inst_en && (!mem_en || last_data);
    grant_data = mem_en && !grant_inst;
  end

  // Completion is routed back only to the granted side; rdata is zero otherwise
  // and also zero on a watchdog expiry.
  always_comb begin
    inst_ready = (state == INST) && done;
    mem_ready  = (state == DATA) && done;
    inst_rdata = ((state == INST) && ram_ready) ? ram_rdata : '0;
    mem_rdata  = ((state == DATA) && ram_ready) ? ram_rdata : '0;
    bus_err    = expired;
    dbg_state  = state;
  end

  // Grant FSM with the registered memory request and round-robin pointer.
  always_ff @(posedge aclk) begin
    if (!srstn) begin
      state     <= IDLE;
      last_data <= 1'b1;
      ram_en    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_strb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst) begin
            state    <= INST;
            ram_en   <= 1'b1;
            ram_wr   <= 1'b0;
            ram_addr <= inst_addr;
            ram_strb <= '0;
          end else if (grant_data) begin
            state     <= DATA;
            ram_en    <= 1'b1;
            ram_wr    <= mem_wr;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            ram_strb  <= mem_strb;
          end
        end
        INST, DATA: begin
          if (done) begin
            state     <= IDLE;
            ram_en    <= 1'b0;
            last_data <= (state == DATA);
          end
        end
        default: begin
          state  <= IDLE;
          ram_en <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog: counts the cycles an access has waited for ram_ready.
  always_ff @(posedge aclk) begin
    if (!srstn) begin
      wd_cnt <= '0;
    end else if (state == IDLE || done) begin
      wd_cnt <= '0;
    end else if (WD_ON && !ram_ready) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// tb_friscv_mem_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_friscv_mem_arbiter;

  localparam int TIMEOUT_T = 8;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } dreq_t;

  // ---------------- clock / reset / DUT ----------------
  logic        aclk = 1'b0;
  logic        srstn = 1'b0;
  logic        inst_en = 1'b0;
  logic [15:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        mem_en = 1'b0;
  logic        mem_wr = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_strb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_wr;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_strb;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;
  logic        bus_err;
  logic [1:0]  dbg_state;

  always #5 aclk = ~aclk;

  friscv_mem_arbiter #(.ADDRW(16), .XLEN(32), .TIMEOUT(TIMEOUT_T)) dut (
    .aclk(aclk), .srstn(srstn),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_strb(ram_strb), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] inst_q[$];
  dreq_t       data_q[$];
  bit          inst_done = 0, data_done = 0;
  bit          auto_en = 0;
  int          inst_rate = 0, data_rate = 0;

  // memory responder: mode 0 fixed latency, 1 random latency, 2 never answers
  int          mem_mode = 0, mem_fix_lat = 0, mem_lat = 0, mem_cnt = 0;
  bit          idle_noise = 0;
  bit          rd_fixed_en = 0;
  logic [31:0] rd_fixed = '0;

  // reference model: who owns the bus, who was served last, how long it waited
  int          m_owner = 0;      // 0 none, 1 inst, 2 data
  bit          m_last_data = 1;
  int          m_wait = 0;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;

  // scoreboard / statistics
  int          grant_q[$];
  int          rise_q[$];
  int          inst_ready_cnt, mem_ready_cnt, bus_err_cnt, inst_issued, data_issued;
  int          inst_issue_cyc, inst_ready_cyc, data_issue_cyc, data_ready_cyc;
  int          en_run = 0, last_run = 0;
  logic        prev_en = 1'b0;
  logic [31:0] last_inst_rdata, last_mem_rdata;
  logic [15:0] g_addr;
  logic        g_wr;
  logic [31:0] g_wdata;
  logic [3:0]  g_strb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    grant_q.delete();
    rise_q.delete();
    inst_ready_cnt = 0; mem_ready_cnt = 0; bus_err_cnt = 0;
    inst_issued = 0; data_issued = 0; last_run = 0;
    inst_issue_cyc = 0; inst_ready_cyc = 0; data_issue_cyc = 0; data_ready_cyc = 0;
  endtask

  task automatic push_data(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                           input logic [3:0] s);
    dreq_t d;
    d.wr = wr; d.addr = a; d.wdata = wd; d.strb = s;
    data_q.push_back(d);
  endtask

  // ---------------- per-cycle monitor + model ----------------
  task automatic check_cycle(input bit rst_n);
    bit          done;
    bit          err;
    logic [31:0] exp_rd;
    if (ram_en === 1'b1 && prev_en !== 1'b1) begin
      rise_q.push_back(cyc);
      g_addr = ram_addr; g_wr = ram_wr; g_wdata = ram_wdata; g_strb = ram_strb;
    end
    if (ram_en === 1'b1) en_run++;
    else if (en_run > 0) begin last_run = en_run; en_run = 0; end
    prev_en = ram_en;
    if (inst_ready === 1'b1) begin
      inst_ready_cnt++; last_inst_rdata = inst_rdata; inst_ready_cyc = cyc; inst_done = 1;
    end
    if (mem_ready === 1'b1) begin
      mem_ready_cnt++; last_mem_rdata = mem_rdata; data_ready_cyc = cyc; data_done = 1;
    end
    if (bus_err === 1'b1) bus_err_cnt++;

    if (m_owner == 0) begin
      chk("idle_ram_en", ram_en, 0);
      chk("idle_inst_ready", inst_ready, 0);
      chk("idle_mem_ready", mem_ready, 0);
      chk("idle_bus_err", bus_err, 0);
      chk("idle_inst_rdata", inst_rdata, 0);
      chk("idle_mem_rdata", mem_rdata, 0);
      m_wait = 0;
      if (rst_n) begin
        if (inst_en && (!mem_en || m_last_data)) begin
          m_owner = 1; m_wr = 1'b0; m_addr = inst_addr; m_strb = '0;
          grant_q.push_back(1);
        end else if (mem_en) begin
          m_owner = 2; m_wr = mem_wr; m_addr = mem_addr; m_wdata = mem_wdata; m_strb = mem_strb;
          grant_q.push_back(2);
        end
      end
    end else begin
      chk("busy_ram_en", ram_en, 1);
      chk("busy_ram_addr", ram_addr, m_addr);
      chk("busy_ram_wr", ram_wr, m_wr);
      chk("busy_ram_strb", ram_strb, m_strb);
      if (m_owner == 2) chk("busy_ram_wdata", ram_wdata, m_wdata);
      done = 0; err = 0; exp_rd = '0;
      if (ram_ready) begin
        done = 1; exp_rd = ram_rdata;
      end else if (m_wait == TIMEOUT_T) begin
        done = 1; err = 1;
      end
      chk("inst_ready", inst_ready, (m_owner == 1) && done);
      chk("mem_ready", mem_ready, (m_owner == 2) && done);
      chk("inst_rdata", inst_rdata, ((m_owner == 1) && done) ? exp_rd : 32'h0);
      chk("mem_rdata", mem_rdata, ((m_owner == 2) && done) ? exp_rd : 32'h0);
      chk("bus_err", bus_err, err);
      if (done) begin
        m_last_data = (m_owner == 2);
        m_owner = 0;
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end
    if (!rst_n) begin
      m_owner = 0; m_last_data = 1; m_wait = 0;
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit rst_n);
    @(posedge aclk);
    #1;
    cyc++;
    srstn = rst_n;
    if (inst_done) begin inst_en = 1'b0; inst_done = 0; end
    if (data_done) begin mem_en = 1'b0; data_done = 0; end
    if (auto_en) begin
      if (inst_q.size() == 0 && $urandom_range(0, 99) < inst_rate)
        inst_q.push_back(16'($urandom) & 16'hFFFC);
      if (data_q.size() == 0 && $urandom_range(0, 99) < data_rate)
        push_data(1'($urandom), 16'($urandom), $urandom, 4'($urandom));
    end
    if (!inst_en && inst_q.size() > 0) begin
      inst_addr = inst_q.pop_front(); inst_en = 1'b1;
      inst_issue_cyc = cyc; inst_issued++;
    end
    if (!mem_en && data_q.size() > 0) begin
      dreq_t d;
      d = data_q.pop_front();
      mem_wr = d.wr; mem_addr = d.addr; mem_wdata = d.wdata; mem_strb = d.strb;
      mem_en = 1'b1; data_issue_cyc = cyc; data_issued++;
    end
    if (ram_en === 1'b1) begin
      if (mem_cnt == 0)
        mem_lat = (mem_mode == 0) ? mem_fix_lat :
                  (mem_mode == 1) ? int'($urandom_range(0, 10)) : 1000;
      ram_ready = (mem_cnt == mem_lat);
      mem_cnt++;
    end else begin
      mem_cnt = 0;
      ram_ready = idle_noise && ($urandom_range(0, 3) == 0);
    end
    ram_rdata = rd_fixed_en ? rd_fixed : $urandom;
    @(negedge aclk);
    check_cycle(rst_n);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    clr();
    repeat (3) step(1'b0);
    step(1'b1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_strb", ram_strb, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_state_idle", dbg_state, 0);

    // single instruction fetch
    clr();
    mem_mode = 0; mem_fix_lat = 0; rd_fixed_en = 1; rd_fixed = 32'h00C12403;
    inst_q.push_back(16'h0010);
    repeat (4) step(1'b1);
    chk("t1_grant_cnt", grant_q.size(), 1);
    chk("t1_grant_inst", grant_q[0], 1);
    chk("t1_ram_addr", g_addr, 16'h0010);
    chk("t1_ram_wr", g_wr, 0);
    chk("t1_inst_ready_cnt", inst_ready_cnt, 1);
    chk("t1_inst_rdata", last_inst_rdata, 32'h00C12403);
    chk("t1_mem_ready_cnt", mem_ready_cnt, 0);
    chk("t1_latency", inst_ready_cyc - inst_issue_cyc, 1);

    // data write
    clr();
    rd_fixed_en = 0;
    push_data(1'b1, 16'h0200, 32'hDEADBEEF, 4'b0011);
    repeat (4) step(1'b1);
    chk("t2_ram_wr", g_wr, 1);
    chk("t2_ram_addr", g_addr, 16'h0200);
    chk("t2_ram_wdata", g_wdata, 32'hDEADBEEF);
    chk("t2_ram_strb", g_strb, 4'b0011);
    chk("t2_mem_ready_cnt", mem_ready_cnt, 1);
    chk("t2_inst_ready_cnt", inst_ready_cnt, 0);
    chk("t2_latency", data_ready_cyc - data_issue_cyc, 1);

    // both requesters held continuously: alternate, one bubble between grants
    step(1'b0);
    step(1'b1);
    clr();
    for (int i = 0; i < 3; i++) begin
      inst_q.push_back(16'h1000 + 16'(4 * i));
      push_data(1'b0, 16'h2000 + 16'(4 * i), 32'h0, 4'hF);
    end
    repeat (14) step(1'b1);
    chk("t3_grant_cnt", grant_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_grant_order", grant_q[i], (i % 2 == 0) ? 1 : 2);
    for (int i = 0; i < 5; i++) chk("t3_grant_spacing", rise_q[i + 1] - rise_q[i], 2);
    chk("t3_inst_done", inst_ready_cnt, 3);
    chk("t3_data_done", mem_ready_cnt, 3);

    // slow memory: request held stable until ram_ready
    clr();
    mem_fix_lat = 5;
    push_data(1'b0, 16'h0300, 32'h0, 4'h0);
    repeat (10) step(1'b1);
    chk("t4_en_cycles", last_run, 6);
    chk("t4_latency", data_ready_cyc - data_issue_cyc, 6);
    chk("t4_mem_ready_cnt", mem_ready_cnt, 1);
    chk("t4_bus_err_cnt", bus_err_cnt, 0);

    // watchdog expiry with the other side pending
    clr();
    mem_mode = 2;
    inst_q.push_back(16'h0040);
    push_data(1'b0, 16'h0080, 32'h0, 4'h0);
    n = 0;
    while (bus_err_cnt == 0 && n < 30) begin step(1'b1); n++; end
    chk("t5_timeout_seen", bus_err_cnt, 1);
    mem_mode = 0; mem_fix_lat = 0;
    repeat (6) step(1'b1);
    chk("t5_bus_err_once", bus_err_cnt, 1);
    chk("t5_grant_cnt", grant_q.size(), 2);
    chk("t5_first_inst", grant_q[0], 1);
    chk("t5_then_data", grant_q[1], 2);
    chk("t5_expiry_span", rise_q[1] - rise_q[0], TIMEOUT_T + 2);
    chk("t5_inst_rdata_zero", last_inst_rdata, 0);
    chk("t5_mem_ready_cnt", mem_ready_cnt, 1);

    // reset while a data access is waiting
    step(1'b0);
    step(1'b1);
    clr();
    mem_mode = 2;
    push_data(1'b1, 16'h0400, 32'h12345678, 4'hF);
    repeat (3) step(1'b1);
    chk("t6_waiting", ram_en, 1);
    mem_mode = 0;
    inst_q.push_back(16'h0100);
    step(1'b0);
    step(1'b1);
    chk("t6_abandon_en", ram_en, 0);
    chk("t6_abandon_idle", dbg_state, 0);
    chk("t6_no_ready", mem_ready_cnt, 0);
    repeat (6) step(1'b1);
    chk("t6_grant_cnt", grant_q.size(), 3);
    chk("t6_inst_after_rst", grant_q[1], 1);
    chk("t6_data_retry", grant_q[2], 2);
    chk("t6_inst_done", inst_ready_cnt, 1);
    chk("t6_data_done", mem_ready_cnt, 1);

    // randomized traffic, random latency, stray ram_ready while idle
    clr();
    mem_mode = 1; idle_noise = 1; auto_en = 1; inst_rate = 40; data_rate = 40;
    repeat (800) step(1'b1);
    auto_en = 0; mem_mode = 0; mem_fix_lat = 0; idle_noise = 0;
    n = 0;
    while ((inst_en || mem_en || inst_q.size() > 0 || data_q.size() > 0) && n < 100) begin
      step(1'b1); n++;
    end
    chk("t7_drained", inst_en || mem_en, 0);
    chk("t7_inst_all_done", inst_ready_cnt, inst_issued);
    chk("t7_data_all_done", mem_ready_cnt, data_issued);
    chk("t7_saw_timeout", bus_err_cnt > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
